// File: rtl/eth_pkg.sv
// eth_pkg: shared types and the header rewrite rule for the Ethernet frame forwarder.
package eth_pkg;
    typedef enum logic [1:0] {PASS = 2'd0, ECHO_SWAP = 2'd1, ECHO_OWN = 2'd2, DROP_ALL = 2'd3} fwd_mode_t;
    typedef enum logic [1:0] {IDLE, STORE, DRAIN, COMMIT} rx_state_t;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
    typedef struct packed {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] ethertype;
    } eth_hdr_t;
    function automatic eth_hdr_t rewrite_hdr(input eth_hdr_t h, input fwd_mode_t m, input logic [47:0] own);
        eth_hdr_t r;
        r = h;
        r.dest = (m == ECHO_SWAP || m == ECHO_OWN) ? h.src : h.dest;
        r.src  = (m == ECHO_SWAP) ? h.dest : (m == ECHO_OWN) ? own : h.src;
        return r;
    endfunction
endpackage

// File: rtl/eth_frame_fifo.sv
// eth_frame_fifo: payload FIFO with speculative writes, commit/rollback, and FWFT read through a registered RAM port.
module eth_frame_fifo #(
    parameter int DEPTH = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       commit,
    input  logic       rollback,
    output logic       full,
    output logic [8:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [8:0] mem [DEPTH];
    logic [AW:0] wr_q, wr_d, com_q, com_d, rd_q, rd_d, used;
    logic vld_q, vld_d, fetch;
    logic [8:0] dat_q;
    // Only committed entries are fetched, so TX never sees a partial frame.
    always_comb begin
        used  = wr_q - rd_q;
        full  = used == (AW+1)'(DEPTH);
        fetch = rd_q != com_q && (!vld_q || rd_ready);
        wr_d  = rollback ? com_q : wr_q + (AW+1)'(wr_en);
        com_d = commit ? wr_q : com_q;
        rd_d  = rd_q + (AW+1)'(fetch);
        vld_d = fetch || (vld_q && !rd_ready);
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            com_q <= '0;
            rd_q  <= '0;
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            wr_q  <= wr_d;
            com_q <= com_d;
            rd_q  <= rd_d;
            vld_q <= vld_d;
            if (fetch) dat_q <= mem[rd_q[AW-1:0]];
        end
    end
    assign rd_data  = dat_q;
    assign rd_valid = vld_q;
endmodule

// File: rtl/eth_frame_forwarder.sv
// eth_frame_forwarder: store-and-forward engine that filters on destination MAC,
// rewrites the header by mode and releases each payload only once fully buffered.
module eth_frame_forwarder
    import eth_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2048,
    parameter logic [47:0] MY_MAC     = 48'h02_00_00_00_00_01,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             promisc,
    input  logic             rx_header_valid,
    input  logic [47:0]      rx_dest_mac,
    input  logic [47:0]      rx_src_mac,
    input  logic [15:0]      rx_ethertype,
    output logic             rx_header_rd,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             tx_header_valid,
    output logic [47:0]      tx_dest_mac,
    output logic [47:0]      tx_src_mac,
    output logic [15:0]      tx_ethertype,
    input  logic             tx_header_rd,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] cnt_fwd,
    output logic [CNT_W-1:0] cnt_filtered,
    output logic [CNT_W-1:0] cnt_overflow
);
    rx_state_t state_q, state_d;
    eth_hdr_t pend_q, pend_d, slot_q, slot_d, rx_hdr;
    logic slot_vld_q, slot_vld_d;
    logic [CNT_W-1:0] fwd_q, fwd_d, filt_q, filt_d, ovf_q, ovf_d;
    logic fifo_full, wr_en, commit, rollback, accept;
    logic [8:0] rd_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction

    always_comb begin
        rx_hdr = '{dest: rx_dest_mac, src: rx_src_mac, ethertype: rx_ethertype};
        accept = fwd_mode_t'(mode) != DROP_ALL &&
                 (promisc || rx_dest_mac == MY_MAC || rx_dest_mac == BROADCAST_MAC);
        state_d    = state_q;
        pend_d     = pend_q;
        slot_d     = slot_q;
        slot_vld_d = slot_vld_q && !tx_header_rd;
        fwd_d      = fwd_q;
        filt_d     = filt_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        rollback   = 1'b0;
        case (state_q)
            IDLE: if (rx_header_valid) begin
                pend_d  = rewrite_hdr(rx_hdr, fwd_mode_t'(mode), MY_MAC);
                state_d = accept ? STORE : DRAIN;
                filt_d  = accept ? filt_q : sat_inc(filt_q);
            end
            // A full FIFO discards the frame; a tlast on that beat has nothing left to drain.
            STORE: if (s_axis_tvalid) begin
                if (fifo_full) begin
                    rollback = 1'b1;
                    ovf_d    = sat_inc(ovf_q);
                    state_d  = s_axis_tlast ? IDLE : DRAIN;
                end else begin
                    wr_en   = 1'b1;
                    state_d = s_axis_tlast ? COMMIT : STORE;
                end
            end
            DRAIN: if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
            COMMIT: if (!slot_vld_q) begin
                commit     = 1'b1;
                slot_d     = pend_q;
                slot_vld_d = 1'b1;
                fwd_d      = sat_inc(fwd_q);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            slot_q     <= '0;
            slot_vld_q <= 1'b0;
            fwd_q      <= '0;
            filt_q     <= '0;
            ovf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            slot_q     <= slot_d;
            slot_vld_q <= slot_vld_d;
            fwd_q      <= fwd_d;
            filt_q     <= filt_d;
            ovf_q      <= ovf_d;
        end
    end

    eth_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  ({s_axis_tlast, s_axis_tdata}),
        .commit   (commit),
        .rollback (rollback),
        .full     (fifo_full),
        .rd_data  (rd_data),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready)
    );

    assign rx_header_rd    = rst_n && state_q == IDLE && rx_header_valid;
    assign s_axis_tready   = state_q == STORE || state_q == DRAIN;
    assign tx_header_valid = slot_vld_q;
    assign tx_dest_mac     = slot_q.dest;
    assign tx_src_mac      = slot_q.src;
    assign tx_ethertype    = slot_q.ethertype;
    assign m_axis_tdata    = rd_data[7:0];
    assign m_axis_tlast    = rd_data[8];
    assign cnt_fwd         = fwd_q;
    assign cnt_filtered    = filt_q;
    assign cnt_overflow    = ovf_q;
endmodule

// File: tb/tb_eth_frame_forwarder.sv
// tb_eth_frame_forwarder: directed scenarios for the store-and-forward engine, 64-entry payload buffer.
module tb_eth_frame_forwarder;
    import eth_pkg::*;
    localparam logic [47:0] MY = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SA = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] SB = 48'h0A_00_00_00_00_0B;
    localparam logic [47:0] SC = 48'h0A_00_00_00_00_0C;
    localparam logic [47:0] SD = 48'h0A_00_00_00_00_0D;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] mode = '0;
    logic promisc = 1'b0, rx_header_valid = 1'b0, rx_header_rd;
    logic [47:0] rx_dest_mac = '0, rx_src_mac = '0, tx_dest_mac, tx_src_mac;
    logic [15:0] rx_ethertype = '0, tx_ethertype;
    logic [7:0] s_axis_tdata = '0, m_axis_tdata;
    logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic tx_header_valid, tx_header_rd = 1'b0;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic [15:0] cnt_fwd, cnt_filtered, cnt_overflow;

    int checks = 0, passes = 0;
    logic [8:0] got_q[$], exp_q[$];
    eth_hdr_t hdr_q[$];
    eth_hdr_t e;
    logic hdr_auto = 1'b1, tog_en = 1'b0;
    int st, st2;

    eth_frame_forwarder #(.FIFO_DEPTH(64), .MY_MAC(MY), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .promisc(promisc),
        .rx_header_valid(rx_header_valid), .rx_dest_mac(rx_dest_mac), .rx_src_mac(rx_src_mac),
        .rx_ethertype(rx_ethertype), .rx_header_rd(rx_header_rd),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .tx_header_valid(tx_header_valid), .tx_dest_mac(tx_dest_mac), .tx_src_mac(tx_src_mac),
        .tx_ethertype(tx_ethertype), .tx_header_rd(tx_header_rd),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .cnt_fwd(cnt_fwd), .cnt_filtered(cnt_filtered), .cnt_overflow(cnt_overflow)
    );

    initial forever #10 clk = ~clk;
    initial forever begin
        @(posedge clk); #1;
        tx_header_rd  = hdr_auto && tx_header_valid;
        m_axis_tready = tog_en ? ~m_axis_tready : 1'b1;
    end
    initial forever begin
        @(negedge clk);
        if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
        if (tx_header_valid && tx_header_rd) hdr_q.push_back('{dest: tx_dest_mac, src: tx_src_mac, ethertype: tx_ethertype});
    end
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] et, input logic [1:0] m, input logic p);
        int n;
        @(posedge clk); #1;
        rx_dest_mac = d; rx_src_mac = s; rx_ethertype = et; mode = m; promisc = p; rx_header_valid = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rx_header_rd) break;
            @(posedge clk); #1;
        end
        if (n == 50) begin checks++; $display("FAIL hdr_accept: rx_header_rd stayed 0, required 1"); end
        @(posedge clk); #1;
        rx_header_valid = 1'b0;
    endtask

    task automatic send_payload(input int base, input int len, input int nsend, output int stalls);
        stalls = 0;
        for (int i = 0; i < nsend; i++) begin
            s_axis_tdata = 8'(base + i); s_axis_tlast = (i == len - 1); s_axis_tvalid = 1'b1;
            for (int w = 0; w < 50; w++) begin
                @(negedge clk);
                if (s_axis_tready) break;
                stalls++;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic build_exp(input int base, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, 8'(base + i)});
    endtask

    task automatic clear_q();
        got_q.delete(); hdr_q.delete(); exp_q.delete();
    endtask

    task automatic wait_out(input string tag, input int nh, input int nb);
        int n;
        for (n = 0; n < 3000 && (hdr_q.size() < nh || got_q.size() < nb); n++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        if (n == 3000) begin
            checks++;
            $display("FAIL %s_timeout: got %0d hdrs %0d beats, required %0d hdrs %0d beats", tag, hdr_q.size(), got_q.size(), nh, nb);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (rx_header_rd !== 1'b0) $display("FAIL rst_hdr_rd: got %b required 0", rx_header_rd); else passes++;
        checks++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %b required 0", s_axis_tready); else passes++;
        checks++; if (tx_header_valid !== 1'b0) $display("FAIL rst_tx_hv: got %b required 0", tx_header_valid); else passes++;
        checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_tvalid: got %b required 0", m_axis_tvalid); else passes++;
        checks++; if ({tx_dest_mac, tx_src_mac, tx_ethertype} !== '0) $display("FAIL rst_tx_hdr: got %h required 0", {tx_dest_mac, tx_src_mac, tx_ethertype}); else passes++;
        checks++; if ({cnt_fwd, cnt_filtered, cnt_overflow} !== '0) $display("FAIL rst_cnt: got %h required 0", {cnt_fwd, cnt_filtered, cnt_overflow}); else passes++;
    endtask

    task automatic test_echo_swap();
        clear_q();
        build_exp(0, 64);
        send_hdr(MY, SA, 16'h0800, 2'd1, 1'b0);
        send_payload(0, 64, 64, st);
        wait_out("swap", 1, 64);
        e = '{dest: SA, src: MY, ethertype: 16'h0800};
        checks++; if (hdr_q.size() !== 1) $display("FAIL swap_hdr_cnt: got %0d required 1", hdr_q.size()); else passes++;
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL swap_hdr: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        checks++; if (got_q.size() !== 64) $display("FAIL swap_len: got %0d required 64", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL swap_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd1) $display("FAIL swap_cnt_fwd: got %0d required 1", cnt_fwd); else passes++;
    endtask

    task automatic test_filter();
        clear_q();
        send_hdr(48'h02_00_00_00_00_99, SA, 16'h0800, 2'd0, 1'b0);
        send_payload(8'h40, 30, 30, st);
        repeat (30) @(posedge clk);
        #1;
        checks++; if (st !== 0) $display("FAIL filt_stalls: got %0d required 0", st); else passes++;
        checks++; if (hdr_q.size() + got_q.size() !== 0) $display("FAIL filt_tx_activity: got %0d items required 0", hdr_q.size() + got_q.size()); else passes++;
        checks++; if (cnt_filtered !== 16'd1) $display("FAIL filt_cnt: got %0d required 1", cnt_filtered); else passes++;
        build_exp(8'h80, 16);
        send_hdr(BROADCAST_MAC, SA, 16'h0806, 2'd0, 1'b0);
        send_payload(8'h80, 16, 16, st);
        wait_out("bcast", 1, 16);
        e = '{dest: BROADCAST_MAC, src: SA, ethertype: 16'h0806};
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL bcast_hdr: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        checks++; if (got_q.size() !== 16) $display("FAIL bcast_len: got %0d required 16", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL bcast_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd2) $display("FAIL bcast_cnt_fwd: got %0d required 2", cnt_fwd); else passes++;
    endtask

    task automatic test_overflow();
        clear_q();
        send_hdr(MY, SA, 16'h88B5, 2'd0, 1'b0);
        send_payload(0, 100, 100, st);
        build_exp(8'hC0, 20);
        send_hdr(MY, SB, 16'h0800, 2'd0, 1'b0);
        send_payload(8'hC0, 20, 20, st2);
        wait_out("ovf", 1, 20);
        e = '{dest: MY, src: SB, ethertype: 16'h0800};
        checks++; if (st !== 0) $display("FAIL ovf_stalls: got %0d required 0", st); else passes++;
        checks++; if (cnt_overflow !== 16'd1) $display("FAIL ovf_cnt: got %0d required 1", cnt_overflow); else passes++;
        checks++; if (hdr_q.size() !== 1) $display("FAIL ovf_hdr_cnt: got %0d required 1", hdr_q.size()); else passes++;
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL ovf_hdr: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        checks++; if (got_q.size() !== 20) $display("FAIL ovf_len: got %0d required 20", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ovf_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd3) $display("FAIL ovf_cnt_fwd: got %0d required 3", cnt_fwd); else passes++;
    endtask

    task automatic test_echo_own();
        clear_q();
        tog_en = 1'b1;
        build_exp(8'h10, 40);
        send_hdr(MY, SB, 16'h86DD, 2'd2, 1'b0);
        send_payload(8'h10, 40, 40, st);
        wait_out("own", 1, 40);
        tog_en = 1'b0;
        e = '{dest: SB, src: MY, ethertype: 16'h86DD};
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL own_hdr: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        checks++; if (got_q.size() !== 40) $display("FAIL own_len: got %0d required 40", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL own_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd4) $display("FAIL own_cnt_fwd: got %0d required 4", cnt_fwd); else passes++;
    endtask

    task automatic test_back_to_back();
        clear_q();
        hdr_auto = 1'b0;
        build_exp(8'h20, 20);
        build_exp(8'h50, 24);
        send_hdr(MY, SC, 16'h0800, 2'd0, 1'b0);
        send_payload(8'h20, 20, 20, st);
        @(negedge clk);
        checks++; if (tx_header_valid !== 1'b0) $display("FAIL b2b_hv_early: got %b required 0", tx_header_valid); else passes++;
        @(negedge clk);
        checks++; if (tx_header_valid !== 1'b1) $display("FAIL b2b_hv_rise: got %b required 1", tx_header_valid); else passes++;
        send_hdr(BROADCAST_MAC, SD, 16'h0801, 2'd1, 1'b0);
        send_payload(8'h50, 24, 24, st);
        repeat (170) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_src_mac !== SC) $display("FAIL b2b_slot_hold: got %h required %h", tx_src_mac, SC); else passes++;
        checks++; if (s_axis_tready !== 1'b0) $display("FAIL b2b_commit_wait: got tready %b required 0", s_axis_tready); else passes++;
        checks++; if (got_q.size() !== 20) $display("FAIL b2b_partial: got %0d beats required 20", got_q.size()); else passes++;
        checks++; if (cnt_fwd !== 16'd5) $display("FAIL b2b_cnt_mid: got %0d required 5", cnt_fwd); else passes++;
        hdr_auto = 1'b1;
        wait_out("b2b", 2, 44);
        e = '{dest: MY, src: SC, ethertype: 16'h0800};
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL b2b_hdr0: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        e = '{dest: SD, src: BROADCAST_MAC, ethertype: 16'h0801};
        checks++; if (hdr_q.size() < 2 || hdr_q[1] !== e) $display("FAIL b2b_hdr1: got %h required %h", hdr_q.size() > 1 ? hdr_q[1] : '0, e); else passes++;
        checks++; if (got_q.size() !== 44) $display("FAIL b2b_len: got %0d required 44", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd6) $display("FAIL b2b_cnt_fwd: got %0d required 6", cnt_fwd); else passes++;
    endtask

    task automatic test_reset_mid();
        clear_q();
        send_hdr(MY, SA, 16'h0800, 2'd0, 1'b0);
        send_payload(0, 64, 10, st);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_header_rd, s_axis_tready, tx_header_valid, tx_dest_mac, tx_src_mac, tx_ethertype, m_axis_tvalid,
             m_axis_tdata, m_axis_tlast, cnt_fwd, cnt_filtered, cnt_overflow} !== '0)
            $display("FAIL midrst_outputs: got %h required 0", {rx_header_rd, s_axis_tready, tx_header_valid, tx_dest_mac,
                     tx_src_mac, tx_ethertype, m_axis_tvalid, m_axis_tdata, m_axis_tlast, cnt_fwd, cnt_filtered, cnt_overflow});
        else passes++;
        build_exp(8'h30, 64);
        send_hdr(MY, SB, 16'h0800, 2'd1, 1'b0);
        send_payload(8'h30, 64, 64, st);
        wait_out("midrst", 1, 64);
        e = '{dest: SB, src: MY, ethertype: 16'h0800};
        checks++; if (hdr_q.size() < 1 || hdr_q[0] !== e) $display("FAIL midrst_hdr: got %h required %h", hdr_q.size() ? hdr_q[0] : '0, e); else passes++;
        checks++; if (got_q.size() !== 64) $display("FAIL midrst_len: got %0d required 64", got_q.size()); else passes++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) $display("FAIL midrst_beat%0d: got %h required %h", i, got_q[i], exp_q[i]); else passes++;
        end
        checks++; if (cnt_fwd !== 16'd1) $display("FAIL midrst_cnt_fwd: got %0d required 1", cnt_fwd); else passes++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_echo_swap();
        test_filter();
        test_overflow();
        test_echo_own();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/eth_frame_forwarder.md
# eth_frame_forwarder

Store-and-forward frame engine between `packet_recv` and `packet_tx` in the 50 MHz RMII domain. Replaces the direct receiver-to-transmitter wiring: it filters received frames on destination MAC, rewrites the MAC header by run-time mode, and buffers each payload completely before launching it. Frames that fail the filter or overflow the buffer are discarded and counted, so the transmitter never underruns mid-frame.

## Interface
- `FIFO_DEPTH`, 2048: payload buffer entries, power of two, ≥ 64
- `MY_MAC`, 48'h02_00_00_00_00_01: station address for filtering and `ECHO_OWN`
- `CNT_W`, 16: statistics counter width
- `clk` in 1: 50 MHz eth clock
- `rst_n` in 1: synchronous, active-low reset
- `mode` in 2: `PASS`=0, `ECHO_SWAP`=1, `ECHO_OWN`=2, `DROP_ALL`=3; sampled at header accept
- `promisc` in 1: accept any destination; sampled at header accept
- `rx_header_valid` in 1: header from receiver valid
- `rx_dest_mac` / `rx_src_mac` in 48, `rx_ethertype` in 16: received header
- `rx_header_rd` out 1: one-cycle pulse consuming the receiver header
- `s_axis_tdata` in 8, `s_axis_tvalid` in 1, `s_axis_tlast` in 1, `s_axis_tready` out 1: payload from receiver
- `tx_header_valid` out 1, `tx_dest_mac` / `tx_src_mac` out 48, `tx_ethertype` out 16, `tx_header_rd` in 1: header to transmitter
- `m_axis_tdata` out 8, `m_axis_tvalid` out 1, `m_axis_tlast` out 1, `m_axis_tready` in 1: payload to transmitter
- `cnt_fwd`, `cnt_filtered`, `cnt_overflow` out CNT_W: saturating statistics

## Operation
- RX FSM states are `IDLE`, `STORE`, `DRAIN` and `COMMIT`.
- `IDLE`:
  - On `rx_header_valid`, pulse `rx_header_rd` and latch the header, `mode` and `promisc`.
  - Accept when `mode != DROP_ALL` and (`promisc` or dest == `MY_MAC` or dest == 48'hFFFF_FFFF_FFFF).
  - Accepted → `STORE`; rejected → `DRAIN` with `cnt_filtered`++.
- `STORE`:
  - Write each beat (data + last) to the FIFO at the speculative write pointer.
  - A beat with `tlast` → `COMMIT`.
  - A beat arriving while the FIFO is full (used == FIFO_DEPTH): roll the write pointer back to the committed pointer, `cnt_overflow`++, → `DRAIN`. That beat is discarded.
- `DRAIN`: `s_axis_tready`=1; discard beats; `tlast` → `IDLE`.
- `COMMIT`:
  - Wait until the TX header slot is empty.
  - Then publish the write pointer, load the slot with the rewritten header, `cnt_fwd`++ → `IDLE`.
- `s_axis_tready` is 1 in `STORE` and `DRAIN`, 0 otherwise.
- Header rewrite:
  - `PASS`: unchanged.
  - `ECHO_SWAP`: dest ← rx src, src ← rx dest.
  - `ECHO_OWN`: dest ← rx src, src ← `MY_MAC`.
  - Ethertype is always unchanged.
- TX side:
  - Slot depth is one. `tx_header_valid` stays high until `tx_header_rd`, which empties the slot.
  - `m_axis_tvalid` is high while read pointer ≠ committed pointer. A beat transfers on `tvalid && tready`.
- Pointers are log2(FIFO_DEPTH)+1 bits with an MSB wrap flag. Used count = wr_spec − rd, modulo 2^(w).
- Counters saturate at all-ones.

## Timing
- Reset values: all outputs 0; FSM `IDLE`; all pointers 0; header slot empty; counters 0.
- `rx_header_rd` is asserted in the same cycle `rx_header_valid` is seen in `IDLE`. It is never asserted outside `IDLE`.
- `tx_header_valid` rises 1 cycle after the `tlast` beat is written, if the slot is empty. Otherwise it rises 1 cycle after the slot frees.
- Payload read latency:
  - FIFO is first-word-fall-through with a registered RAM read.
  - `m_axis_tvalid` rises ≤ 2 cycles after commit.
  - Sustained rate is 1 beat per cycle.
- Simultaneous FIFO read and write in one cycle are both honoured. Full is evaluated before the same-cycle read.
- A frame longer than FIFO_DEPTH always overflows. Partially committed data is never exposed to TX.
- `rst_n` low mid-frame: the in-flight frame is lost and all state returns to reset values on the next edge. Upstream shares the reset.

## Structure
- Package `eth_pkg`:
  - `fwd_mode_t` enum
  - `BROADCAST_MAC` constant
  - `eth_hdr_t` struct {dest, src, ethertype}
- Sub-module `eth_frame_fifo`: commit/rollback FIFO holding 9-bit entries, with `commit` and `rollback` strobes and FWFT read.
- Top holds the RX FSM, rewrite logic, header slot and counters.

## Test plan
- Unicast to `MY_MAC`, `ECHO_SWAP`, 64-byte payload 0x00..0x3F:
  - TX header dest/src swapped.
  - Identical 64 beats, `tlast` on 0x3F.
  - `cnt_fwd`=1.
- Dest 02:00:00:00:00:99, `promisc`=0:
  - `s_axis_tready` high throughout, no TX activity.
  - `cnt_filtered`=1.
  - A following broadcast frame is forwarded.
- `FIFO_DEPTH`=64, 100-byte frame, then 20-byte frame:
  - First frame dropped, `cnt_overflow`=1.
  - Second forwarded intact.
- `ECHO_OWN` with `m_axis_tready` toggling 50 %: src = `MY_MAC`, dest = rx src, no beat lost or duplicated.
- Two back-to-back frames, `tx_header_rd` held off 200 cycles:
  - Second frame waits in `COMMIT`.
  - Headers and payloads emerge in order.
- `rst_n` low for 1 cycle at beat 10 of a 64-byte frame:
  - All outputs 0 next cycle.
  - The next full frame is forwarded correctly.
